serial_slave_mem: RTL

Bit-serial memory slave that terminates the serial system bus on the slave side. It consumes the bit stream a bus master drives (`mwdata`/`mmode`/`mvalid`), deserialises a local address and optional write word, and performs the access on an internal synchronous RAM. For reads it streams the word back serially (`srdata`/`svalid`). It signals completion to the master on `ack`.

---
 rtl/serial_slave_mem_if.sv | 32 +++
 rtl/serial_slave_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_slave_mem_if.sv
// Serial system bus between a bit-serial master and a memory slave.
// The master drives address/write bits LSB first; the slave streams
// read data back and pulses ack when a frame completes.
interface serial_slave_mem_if;
    logic mwdata;   // serial address / write-data bit from the master
    logic mmode;    // 0 = read, 1 = write (meaningful with the first bit only)
    logic mvalid;   // mwdata valid this cycle
    logic srdata;   // serial read-data bit back to the master
    logic svalid;   // srdata valid this cycle
    logic sready;   // slave is accepting master bits
    logic ack;      // one-cycle frame completion pulse

    modport master (
        output mwdata,
        output mmode,
        output mvalid,
        input  srdata,
        input  svalid,
        input  sready,
        input  ack
    );

    modport slave (
        input  mwdata,
        input  mmode,
        input  mvalid,
        output srdata,
        output svalid,
        output sready,
        output ack
    );
endinterface

// File: rtl/serial_slave_mem.sv
// Bit-serial memory slave. Deserialises an address (and a data word for
// writes) from the serial bus, accesses an internal RAM and, for reads,
// streams the word back LSB first. A stalled frame is abandoned after
// TIMEOUT idle cycles. All bus outputs come straight from flops.
module serial_slave_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    serial_slave_mem_if.slave    bus
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Depth widened by one bit so a full 2^ADDR_WIDTH memory does not wrap to 0.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_RLOAD = 3'd4,
        ST_RDATA = 3'd5
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [TMO_W-1:0]        tmo_r, tmo_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s;
    logic [DATA_WIDTH-1:0]   data_r, data_nxt_s;
    logic                    mode_r, mode_nxt_s;
    logic [DATA_WIDTH-1:0]   shreg_r, shreg_nxt_s;
    logic                    sready_r, sready_nxt_s;
    logic                    svalid_r, svalid_nxt_s;
    logic                    ack_r, ack_nxt_s;
    logic                    mem_we_s;
    logic [IDX_W-1:0]        idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    // Out-of-range addresses alias onto the RAM modulo its depth.
    always_comb begin
        idx_s = IDX_W'({1'b0, addr_r} % DEPTH_EXT);
    end

    // RAM read port; sampled into the output shift register in RLOAD.
    always_comb begin
        rd_word_s = mem_r[idx_s];
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= data_r;
        end
    end

    // Next-state, datapath and timeout logic for the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        tmo_nxt_s   = tmo_r;
        addr_nxt_s  = addr_r;
        data_nxt_s  = data_r;
        mode_nxt_s  = mode_r;
        shreg_nxt_s = shreg_r;
        mem_we_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tmo_nxt_s = {TMO_W{1'b0}};
                if (bus.mvalid) begin
                    addr_nxt_s  = {bus.mwdata, addr_r[ADDR_WIDTH-1:1]};
                    mode_nxt_s  = bus.mmode;
                    cnt_nxt_s   = CNT_W'(1);
                    state_nxt_s = ST_ADDR;
                end else begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end

            ST_ADDR: begin
                if (bus.mvalid) begin
                    addr_nxt_s = {bus.mwdata, addr_r[ADDR_WIDTH-1:1]};
                    tmo_nxt_s  = {TMO_W{1'b0}};
                    if (cnt_r == CNT_W'(ADDR_WIDTH - 1)) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = mode_r ? ST_WDATA : ST_RLOAD;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
                    tmo_nxt_s   = {TMO_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmo_nxt_s   = tmo_r + TMO_W'(1);
                end
            end

            ST_WDATA: begin
                if (bus.mvalid) begin
                    data_nxt_s = {bus.mwdata, data_r[DATA_WIDTH-1:1]};
                    tmo_nxt_s  = {TMO_W{1'b0}};
                    if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = ST_WRITE;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
                    tmo_nxt_s   = {TMO_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmo_nxt_s   = tmo_r + TMO_W'(1);
                end
            end

            ST_WRITE: begin
                mem_we_s    = 1'b1;
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end

            ST_RLOAD: begin
                shreg_nxt_s = rd_word_s;
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = ST_RDATA;
            end

            ST_RDATA: begin
                shreg_nxt_s = {1'b0, shreg_r[DATA_WIDTH-1:1]};
                if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                tmo_nxt_s   = {TMO_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // that the flopped outputs line up with the state they describe.
    always_comb begin
        sready_nxt_s = 1'b0;
        svalid_nxt_s = 1'b0;
        ack_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_IDLE, ST_ADDR, ST_WDATA: begin
                sready_nxt_s = 1'b1;
            end
            ST_WRITE: begin
                ack_nxt_s = 1'b1;
            end
            ST_RDATA: begin
                svalid_nxt_s = 1'b1;
                if (cnt_nxt_s == CNT_W'(DATA_WIDTH - 1)) begin
                    ack_nxt_s = 1'b1;
                end else begin
                    ack_nxt_s = 1'b0;
                end
            end
            default: begin
                sready_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            tmo_r    <= {TMO_W{1'b0}};
            addr_r   <= {ADDR_WIDTH{1'b0}};
            data_r   <= {DATA_WIDTH{1'b0}};
            mode_r   <= 1'b0;
            shreg_r  <= {DATA_WIDTH{1'b0}};
            sready_r <= 1'b1;
            svalid_r <= 1'b0;
            ack_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            tmo_r    <= tmo_nxt_s;
            addr_r   <= addr_nxt_s;
            data_r   <= data_nxt_s;
            mode_r   <= mode_nxt_s;
            shreg_r  <= shreg_nxt_s;
            sready_r <= sready_nxt_s;
            svalid_r <= svalid_nxt_s;
            ack_r    <= ack_nxt_s;
        end
    end

    assign bus.srdata = shreg_r[0];
    assign bus.svalid = svalid_r;
    assign bus.sready = sready_r;
    assign bus.ack    = ack_r;

endmodule
